// File: rtl/dma_copy_engine_if.sv
// Byte-wide MiniRISC data-bus port, shared by the CPU-facing register window and
// the DMA master port of dma_copy_engine.
//   mst2slv_addr/wr/rd/data : master -> slave address, strobes and write data
//   slv2mst_data            : slave -> master read data (OR-bus, 0 when idle)
//   bus_req / bus_grant     : arbitration handshake (master side only)
interface dma_copy_engine_if;
    logic [7:0] mst2slv_addr;
    logic       mst2slv_wr;
    logic       mst2slv_rd;
    logic [7:0] mst2slv_data;
    logic [7:0] slv2mst_data;
    logic       bus_req;
    logic       bus_grant;

    modport master (
        output mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data, bus_req,
        input  slv2mst_data, bus_grant
    );

    modport slave (
        input  mst2slv_addr, mst2slv_wr, mst2slv_rd, mst2slv_data,
        output slv2mst_data
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Memory-to-memory byte copy engine. Programmed by the CPU through a 4-byte register
// window (SRC, DST, LEN, CTRL) and copies LEN bytes from SRC to DST as bus master,
// one byte per two granted cycles, in ascending address order.
//   clk, rst : system clock, synchronous active-high reset
//   s        : slave port (register window), combinational reads, writes at posedge
//   m        : master port (req/grant plus bus), outputs gated by grant
//   irq      : level interrupt, DONE & IEN (registered)
module dma_copy_engine #(
    parameter logic [7:0] BASE_ADDR = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    dma_copy_engine_if.slave  s,
    dma_copy_engine_if.master m,
    output logic              irq
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e     state_q;
    logic [7:0] src_q, dst_q, len_q, buf_q;
    logic       done_q, done_d;
    logic       ien_q, ien_d;
    logic       irq_q;

    logic busy, sel, start;
    logic wr_src, wr_dst, wr_len, wr_ctrl;

    assign busy = (state_q != StIdle);
    // The window is never decoded while our own master cycle owns the bus.
    assign sel     = (s.mst2slv_addr[7:2] == BASE_ADDR[7:2]) && !m.bus_grant;
    assign wr_src  = sel && s.mst2slv_wr && (s.mst2slv_addr[1:0] == 2'd0);
    assign wr_dst  = sel && s.mst2slv_wr && (s.mst2slv_addr[1:0] == 2'd1);
    assign wr_len  = sel && s.mst2slv_wr && (s.mst2slv_addr[1:0] == 2'd2);
    assign wr_ctrl = sel && s.mst2slv_wr && (s.mst2slv_addr[1:0] == 2'd3);
    assign start   = wr_ctrl && s.mst2slv_data[0];

    // DONE/IEN next values feed both their registers and irq, so irq tracks them
    // in the very cycle they change. Completion is applied last so it beats a clear.
    always_comb begin
        ien_d  = wr_ctrl ? s.mst2slv_data[1] : ien_q;
        done_d = done_q;
        if (wr_ctrl && s.mst2slv_data[6]) begin
            done_d = 1'b0;
        end
        if ((state_q == StIdle) && start) begin
            done_d = (len_q == 8'd0);
        end
        if ((state_q == StWrite) && m.bus_grant && (len_q == 8'd1)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            len_q   <= 8'h00;
            buf_q   <= 8'h00;
            done_q  <= 1'b0;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            ien_q  <= ien_d;
            irq_q  <= done_d & ien_d;
            unique case (state_q)
                StIdle: begin
                    if (wr_src) src_q <= s.mst2slv_data;
                    if (wr_dst) dst_q <= s.mst2slv_data;
                    if (wr_len) len_q <= s.mst2slv_data;
                    if (start && (len_q != 8'd0)) state_q <= StRead;
                end
                StRead: begin
                    if (m.bus_grant) begin
                        buf_q   <= m.slv2mst_data;
                        src_q   <= src_q + 8'd1;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (m.bus_grant) begin
                        dst_q   <= dst_q + 8'd1;
                        len_q   <= len_q - 8'd1;
                        state_q <= (len_q == 8'd1) ? StIdle : StRead;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        m.bus_req      = busy;
        m.mst2slv_addr = 8'h00;
        m.mst2slv_rd   = 1'b0;
        m.mst2slv_wr   = 1'b0;
        m.mst2slv_data = 8'h00;
        if (m.bus_grant) begin
            if (state_q == StRead) begin
                m.mst2slv_addr = src_q;
                m.mst2slv_rd   = 1'b1;
            end else if (state_q == StWrite) begin
                m.mst2slv_addr = dst_q;
                m.mst2slv_wr   = 1'b1;
                m.mst2slv_data = buf_q;
            end
        end
    end

    always_comb begin
        s.slv2mst_data = 8'h00;
        if (sel && s.mst2slv_rd) begin
            unique case (s.mst2slv_addr[1:0])
                2'd0: s.slv2mst_data = src_q;
                2'd1: s.slv2mst_data = dst_q;
                2'd2: s.slv2mst_data = len_q;
                2'd3: s.slv2mst_data = {busy, done_q, 4'b0000, ien_q, 1'b0};
                default: s.slv2mst_data = 8'h00;
            endcase
        end
    end

    assign irq = irq_q;
endmodule
